parking_gate_arbiter: RTL and testbench
=======================================

// Module: parking_gate_arbiter
// PURPOSE
//  Shares the single Parking counter core between NUM_GATES entry/exit gates.
//  Serves one gate request at a time, in round-robin order.
//  Checks each request against the core's status (pc, upc, vs, uvs), so the core
//  never sees a full-lot entry or an empty-lot exit.
//  Drives the core's one-cycle ci/uci/ce/uce strobes, answers the gate with
//  ack or nack, and times each gate's barrier.
// PARAMETERS
//  NUM_GATES       4   number of requesting gates (2..8)
//  SETTLE_CYCLES   2   cycles to wait after a strobe for the core counters to update (>=1)
//  BARRIER_CYCLES  8   cycles barrier_open[g] stays high after an ack (>=1)
// PORTS
//  clk           in   1             system clock, rising edge
//  rst_n         in   1             asynchronous, active-low reset
//  gate_req      in   NUM_GATES     per-gate request; held until ack/nack
//  gate_type     in   2*NUM_GATES   per-gate kind, bits [2g+1:2g]:
//                                   00 car in, 01 univ car in, 10 car exit, 11 univ car exit
//  pc, upc       in   11 each       parked counts from the core
//  vs, uvs       in   11 each       vacant spaces from the core
//  ci, uci       out  1 each        entry strobes to the core
//  ce, uce       out  1 each        exit strobes to the core
//  gate_ack      out  NUM_GATES     one-cycle accept pulse to the served gate
//  gate_nack     out  NUM_GATES     one-cycle refuse pulse to the served gate
//  barrier_open  out  NUM_GATES     gate barrier raised
//  busy          out  1             high in any state except IDLE
//  deny_cnt      out  16            saturating count of nacks
// BEHAVIOUR
//  Reset
//   - All outputs 0; FSM in IDLE; rr pointer 0; barrier timers 0.
//   - Takes effect immediately, including mid-transaction. No ack or strobe is
//     issued for a request in flight; that gate must re-request.
//  Registers
//   - All outputs registered.
//   - At most one of ci/uci/ce/uce is high in any cycle, for exactly one cycle.
//  States: IDLE, CHECK, SETTLE, COOL
//   - IDLE:
//     - Eligible gate: gate_req[g]=1 and barrier_open[g]=0.
//     - Winner: first eligible gate at or after the rr pointer, wrapping modulo NUM_GATES.
//     - Latch winner index and its gate_type; go to CHECK.
//     - rr pointer <= (winner+1) mod NUM_GATES.
//   - CHECK: legality, using status sampled this cycle:
//     - 00 needs vs!=0; 01 needs uvs!=0; 10 needs pc!=0; 11 needs upc!=0.
//     - Legal: register the matching strobe high for one cycle; load settle
//       counter with SETTLE_CYCLES-1; go to SETTLE.
//     - Illegal: register gate_nack[idx] high for one cycle; deny_cnt +1,
//       saturating at 16'hFFFF; go to COOL.
//   - SETTLE:
//     - Counter nonzero: decrement.
//     - Counter 0: register gate_ack[idx] high for one cycle; load barrier
//       timer[idx] with BARRIER_CYCLES; go to COOL.
//   - COOL: one cycle; req from the just-served gate is ignored; return to IDLE.
//  Timing
//   - Strobe is high the cycle after the CHECK edge.
//   - Ack is high exactly SETTLE_CYCLES cycles after the strobe.
//   - Nack is high the cycle after the CHECK edge.
//   - A gate must drop req in the cycle it sees ack/nack. A req still held
//     after COOL counts as a new request.
//  Latched request
//   - Kind and index are frozen at arbitration.
//   - Changes to req or type after the IDLE edge do not affect the transaction.
//  Barrier
//   - barrier_open[g] = (timer[g] != 0).
//   - Each timer decrements once per cycle, independently of the FSM.
//   - A gate with its barrier open is not eligible.
//  Simultaneous requests: only one is served per transaction; the others wait,
//  with no loss.
// TESTING  (NUM_GATES=4, SETTLE_CYCLES=2, BARRIER_CYCLES=8)
//  1. Reset: rst_n=0 for 3 cycles with gate_req=4'hF -> all outputs 0, busy=0,
//     no strobes.
//  2. Gate0 type 00, vs=5 -> ci high 1 cycle; gate_ack[0] 2 cycles later;
//     barrier_open[0] high exactly 8 cycles.
//  3. Gate1 type 00, vs=0 -> no strobe; gate_nack[1] 1 cycle; deny_cnt=1.
//     Gate1 type 10, pc=0 -> nack; deny_cnt=2.
//  4. Gates 0, 2, 3 request together, pointer=0 -> served in order 0, 2, 3.
//     Pointer ends at 0; busy stays high between transactions except 1 IDLE cycle.
//  5. Gate3 type 11, upc=3 -> uce pulse then ack.
//     Gate3 re-requests while its barrier is open -> ignored until barrier_open[3]=0.
//  6. rst_n low during SETTLE of a gate2 type 01 transaction -> no ack and
//     barrier_open[2]=0.
//     After release, gate2 re-requests -> uci and ack served normally.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: round-robin arbiter sharing one parking counter core between
// several entry/exit gates, with legality checks, core strobes and per-gate barrier timers.
module parking_gate_arbiter #(
   parameter int NUM_GATES      = 4,
   parameter int SETTLE_CYCLES  = 2,
   parameter int BARRIER_CYCLES = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_GATES-1:0]   gate_req,
   input  logic [2*NUM_GATES-1:0] gate_type,
   input  logic [10:0]            pc,
   input  logic [10:0]            upc,
   input  logic [10:0]            vs,
   input  logic [10:0]            uvs,
   output logic                   ci,
   output logic                   uci,
   output logic                   ce,
   output logic                   uce,
   output logic [NUM_GATES-1:0]   gate_ack,
   output logic [NUM_GATES-1:0]   gate_nack,
   output logic [NUM_GATES-1:0]   barrier_open,
   output logic                   busy,
   output logic [15:0]            deny_cnt
);
   localparam int IW = $clog2(NUM_GATES);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int BW = $clog2(BARRIER_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, CHECK, SETTLE, COOL} state_t;

   state_t         state;
   logic [IW-1:0]  rr, idx, win, j;
   logic [1:0]     kind;
   logic [SW-1:0]  cnt;
   logic [3:0]     strb;
   logic           found, legal, load;
   logic [1:0]     types [NUM_GATES];

   assign {uce, ce, uci, ci} = strb;
   assign load  = state == SETTLE && cnt == '0;
   assign legal = kind == 2'd0 ? vs != '0 :
                  kind == 2'd1 ? uvs != '0 :
                  kind == 2'd2 ? pc != '0 : upc != '0;

   // Scanning downward lets the gate closest to rr overwrite farther winners.
   always_comb begin
      win   = '0;
      found = 1'b0;
      j     = '0;
      for (int i = NUM_GATES - 1; i >= 0; i--) begin
         j = IW'((int'(rr) + i) % NUM_GATES);
         if (gate_req[j] && !barrier_open[j]) begin
            win   = j;
            found = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
      logic [BW-1:0] t;
      assign types[g]        = gate_type[2*g +: 2];
      assign barrier_open[g] = t != '0;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) t <= '0;
         else t <= (load && idx == IW'(g)) ? BW'(BARRIER_CYCLES) : t - BW'(t != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr        <= '0;
         idx       <= '0;
         kind      <= '0;
         cnt       <= '0;
         strb      <= '0;
         gate_ack  <= '0;
         gate_nack <= '0;
         busy      <= 1'b0;
         deny_cnt  <= '0;
      end else begin
         strb      <= '0;
         gate_ack  <= '0;
         gate_nack <= '0;
         case (state)
            IDLE:
               if (found) begin
                  idx   <= win;
                  kind  <= types[win];
                  rr    <= (win == IW'(NUM_GATES - 1)) ? '0 : win + 1'b1;
                  state <= CHECK;
                  busy  <= 1'b1;
               end
            CHECK:
               if (legal) begin
                  strb  <= 4'b0001 << kind;
                  cnt   <= SW'(SETTLE_CYCLES - 1);
                  state <= SETTLE;
               end else begin
                  gate_nack[idx] <= 1'b1;
                  deny_cnt       <= deny_cnt + {15'd0, deny_cnt != 16'hFFFF};
                  state          <= COOL;
               end
            SETTLE:
               if (cnt != '0) cnt <= cnt - 1'b1;
               else begin
                  gate_ack[idx] <= 1'b1;
                  state         <= COOL;
               end
            COOL: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: directed steps with an event scoreboard for strobes,
// acks and nacks, plus cycle-exact timing checks.
module tb_parking_gate_arbiter;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [3:0]  gate_req = '0;
   logic [7:0]  gate_type = '0;
   logic [10:0] pc = '0, upc = '0, vs = '0, uvs = '0;
   logic        ci, uci, ce, uce, busy;
   logic [3:0]  gate_ack, gate_nack, barrier_open;
   logic [15:0] deny_cnt;
   int          checks = 0, failures = 0;
   int          n, bad;
   int          q[$];

   parking_gate_arbiter #(.NUM_GATES(4), .SETTLE_CYCLES(2), .BARRIER_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .gate_req(gate_req), .gate_type(gate_type),
      .pc(pc), .upc(upc), .vs(vs), .uvs(uvs),
      .ci(ci), .uci(uci), .ce(ce), .uce(uce),
      .gate_ack(gate_ack), .gate_nack(gate_nack), .barrier_open(barrier_open),
      .busy(busy), .deny_cnt(deny_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Event codes: 100+k strobe (ci,uci,ce,uce), 200+g ack, 300+g nack.
   task automatic see(input int code);
      int e;
      e = q.size() != 0 ? q.pop_front() : -1;
      check("sb_event", code, e);
   endtask

   always @(negedge clk)
      if (rst_n) begin
         logic [3:0] s;
         s = {uce, ce, uci, ci};
         if (s != 4'd0) check("one_strobe", $countones(s), 1);
         for (int k = 0; k < 4; k++) if (s[k]) see(100 + k);
         for (int k = 0; k < 4; k++) if (gate_ack[k]) see(200 + k);
         for (int k = 0; k < 4; k++) if (gate_nack[k]) see(300 + k);
      end

   task automatic txn(input logic [1:0] g, input logic [1:0] t, input bit legal);
      int m;
      m = 0;
      gate_type[{g, 1'b0} +: 2] = t;
      if (legal) begin
         q.push_back(100 + int'(t));
         q.push_back(200 + int'(g));
      end else q.push_back(300 + int'(g));
      gate_req[g] = 1'b1;
      while (!(gate_ack[g] || gate_nack[g]) && m < 30) begin
         tick();
         m++;
      end
      check("txn_latency", m, legal ? 4 : 2);
      check("txn_is_ack", 32'(gate_ack[g]), 32'(legal));
      gate_req[g] = 1'b0;
      tick();
   endtask

   task automatic multi(input logic [3:0] mask);
      int m, acks, idle;
      m = 0;
      acks = 0;
      idle = 0;
      gate_req = mask;
      tick();
      while (acks < $countones(mask) && m < 80) begin
         if (!busy) idle++;
         for (int k = 0; k < 4; k++)
            if (gate_ack[k]) begin
               gate_req[k] = 1'b0;
               acks++;
            end
         tick();
         m++;
      end
      check("multi_acks", acks, $countones(mask));
      check("multi_idle_cycles", idle, $countones(mask) - 1);
   endtask

   initial begin
      gate_req = 4'hF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_outputs", 32'({ci, uci, ce, uce, gate_ack, gate_nack, barrier_open, busy}), 0);
         check("rst_deny", 32'(deny_cnt), 0);
      end
      gate_req = '0;
      rst_n = 1'b1;
      tick();
      check("idle_busy", 32'(busy), 0);

      vs = 11'd5;
      uvs = 11'd5;
      q.push_back(100);
      q.push_back(200);
      gate_req[0] = 1'b1;
      tick();
      check("t2_busy", 32'(busy), 1);
      check("t2_no_strobe_yet", 32'(ci), 0);
      tick();
      check("t2_ci", 32'(ci), 1);
      tick();
      check("t2_ci_one_cycle", 32'(ci), 0);
      check("t2_ack_early", 32'(gate_ack), 0);
      tick();
      check("t2_ack", 32'(gate_ack), 32'h1);
      gate_req[0] = 1'b0;
      n = 0;
      while (barrier_open[0] && n < 20) begin
         n++;
         tick();
      end
      check("t2_barrier_len", n, 8);

      vs = 11'd0;
      txn(2'd1, 2'b00, 1'b0);
      check("t3_deny1", 32'(deny_cnt), 1);
      txn(2'd1, 2'b10, 1'b0);
      check("t3_deny2", 32'(deny_cnt), 2);
      txn(2'd3, 2'b00, 1'b0);
      check("t3_deny3", 32'(deny_cnt), 3);

      vs = 11'd5;
      pc = 11'd5;
      upc = 11'd3;
      gate_type = 8'b01_10_00_00;
      q.push_back(100); q.push_back(200);
      q.push_back(102); q.push_back(202);
      q.push_back(101); q.push_back(203);
      multi(4'b1101);
      repeat (10) tick();
      q.push_back(100); q.push_back(200);
      q.push_back(100); q.push_back(201);
      multi(4'b0011);
      repeat (10) tick();

      txn(2'd3, 2'b11, 1'b1);
      q.push_back(103);
      q.push_back(203);
      gate_req[3] = 1'b1;
      n = 0;
      bad = 0;
      while (barrier_open[3] && n < 20) begin
         if (busy) bad++;
         tick();
         n++;
      end
      check("t5_blocked_busy", bad, 0);
      check("t5_barrier_left", n, 7);
      n = 0;
      while (!gate_ack[3] && n < 20) begin
         tick();
         n++;
      end
      check("t5_ack_after_barrier", n, 4);
      gate_req[3] = 1'b0;
      tick();

      gate_type[5:4] = 2'b01;
      q.push_back(101);
      gate_req[2] = 1'b1;
      repeat (3) tick();
      check("t6_in_settle", 32'(busy), 1);
      rst_n = 1'b0;
      gate_req[2] = 1'b0;
      #1;
      check("t6_rst_outputs", 32'({gate_ack, barrier_open, busy}), 0);
      tick();
      tick();
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (gate_ack != 4'd0 || barrier_open != 4'd0 || busy) bad++;
      end
      check("t6_no_ack_after_rst", bad, 0);
      txn(2'd2, 2'b01, 1'b1);

      repeat (3) tick();
      check("sb_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
